// File: rtl/ecc_pkg.sv
// Helpers shared by the SECDED decoder and its syndrome block: check-bit sizing
// and the mapping from data bit index to Hamming position.
package ecc_pkg;

   function automatic int ecc_pw(input int data_w);
      int r;
      r = 1;
      while ((1 << r) < data_w + r + 1) r++;
      return r;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   // Data bits fill the non-power-of-two positions in ascending order, d[0] at 3.
   function automatic int data_pos(input int i);
      int pos;
      int n;
      pos = 2;
      n   = -1;
      while (n < i) begin
         pos++;
         if (!is_pow2(pos)) n++;
      end
      return pos;
   endfunction

   function automatic int ecc_w(input int data_w);
      return ecc_pw(data_w) + 1;
   endfunction

   function automatic int cw_n(input int data_w);
      return data_w + ecc_pw(data_w);
   endfunction

   localparam int DEF_DATA_W = 32;
   localparam int DEF_P_W    = ecc_pw(DEF_DATA_W);
   localparam int DEF_ECC_W  = DEF_P_W + 1;
   localparam int DEF_CW_N   = DEF_DATA_W + DEF_P_W;

endpackage

// File: rtl/ecc_secded_syndrome.sv
// Combinational codeword assembly, Hamming syndrome and overall-parity check.
// Shared between the decoder front stage and the encoder.
module ecc_secded_syndrome
   import ecc_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int P_W    = ecc_pw(DATA_W),
   localparam int ECC_W  = P_W + 1,
   localparam int CW_N   = DATA_W + P_W
) (
   input  logic [DATA_W-1:0] d,
   input  logic [ECC_W-1:0]  ecc,
   output logic [CW_N:1]     cw,
   output logic [P_W-1:0]    syn,
   output logic              overall_err
);

   for (genvar i = 0; i < DATA_W; i++) begin : g_data
      assign cw[data_pos(i)] = d[i];
   end

   for (genvar k = 0; k < P_W; k++) begin : g_par
      assign cw[1 << k] = ecc[k+1];
   end

   always_comb begin
      syn = '0;
      for (int j = 1; j <= CW_N; j++) begin
         for (int k = 0; k < P_W; k++) begin
            if (j[k]) syn[k] = syn[k] ^ cw[j];
         end
      end
      overall_err = ecc[0] ^ (^cw);
   end

endmodule

// File: rtl/ecc_secded_dec_pipe.sv
// Two-stage SECDED decoder with valid/ready flow control, saturating error
// counters and a last-error capture.
module ecc_secded_dec_pipe
   import ecc_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int CNT_W  = 16,
   localparam int P_W    = ecc_pw(DATA_W),
   localparam int ECC_W  = P_W + 1,
   localparam int CW_N   = DATA_W + P_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] d_in,
   input  logic [ECC_W-1:0]  ecc_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] d_out,
   output logic              sec_err,
   output logic              ded_err,
   output logic [P_W-1:0]    syn_out,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  sec_cnt,
   output logic [CNT_W-1:0]  ded_cnt,
   output logic [P_W-1:0]    last_syn,
   output logic              last_ded
);

   localparam logic [P_W-1:0] CW_N_S = P_W'(CW_N);

   logic [CW_N:1]     cw_c;
   logic [P_W-1:0]    syn_c;
   logic              oerr_c;
   logic              s1_valid;
   logic [CW_N:1]     s1_cw;
   logic [P_W-1:0]    s1_syn;
   logic              s1_oerr;
   logic              s2_adv;
   logic              in_range;
   logic              sec_c;
   logic              ded_c;
   logic              do_fix;
   logic [CW_N:1]     fix;
   logic [DATA_W-1:0] d_fix;
   logic              flag_hs;

   ecc_secded_syndrome #(.DATA_W(DATA_W)) u_syn (
      .d           (d_in),
      .ecc         (ecc_in),
      .cw          (cw_c),
      .syn         (syn_c),
      .overall_err (oerr_c)
   );

   assign s2_adv   = !out_valid | out_ready;
   assign in_ready = !s1_valid | s2_adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_syn   <= '0;
         s1_oerr  <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_cw   <= cw_c;
            s1_syn  <= syn_c;
            s1_oerr <= oerr_c;
         end
      end
   end

   // Odd overall parity with a syndrome beyond the codeword cannot be a single error.
   assign in_range = s1_syn <= CW_N_S;
   assign sec_c    = s1_oerr & in_range;
   assign ded_c    = s1_oerr ? !in_range : (s1_syn != '0);
   assign do_fix   = sec_c & (s1_syn != '0);

   always_comb begin
      fix = '0;
      for (int j = 1; j <= CW_N; j++) begin
         if (do_fix && s1_syn == P_W'(j)) fix[j] = 1'b1;
      end
   end

   for (genvar i = 0; i < DATA_W; i++) begin : g_ext
      assign d_fix[i] = s1_cw[data_pos(i)] ^ fix[data_pos(i)];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         d_out     <= '0;
         sec_err   <= 1'b0;
         ded_err   <= 1'b0;
         syn_out   <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            d_out   <= d_fix;
            sec_err <= sec_c;
            ded_err <= ded_c;
            syn_out <= s1_syn;
         end
      end
   end

   assign flag_hs = out_valid & out_ready & (sec_err | ded_err);

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         sec_cnt  <= '0;
         ded_cnt  <= '0;
         last_syn <= '0;
         last_ded <= 1'b0;
      end else if (flag_hs) begin
         if (sec_err && sec_cnt != '1) sec_cnt <= sec_cnt + CNT_W'(1);
         if (ded_err && ded_cnt != '1) ded_cnt <= ded_cnt + CNT_W'(1);
         last_syn <= syn_out;
         last_ded <= ded_err;
      end
   end

endmodule
